// File: rtl/nes_timing_pkg.sv
// Shared NES timing constants: master-clock cycles per PPU, CPU and APU tick.
// NTSC ratios: the PPU runs at master/4 and the CPU at master/12.
package nes_timing_pkg;

  localparam int MASTER_PER_PPU = 4;
  localparam int MASTER_PER_CPU = 12;
  localparam int MASTER_PER_APU = 24;

  // Whether a divider chain ratio is usable: the slow clock must land on fast ticks.
  function automatic bit div_compatible(input int fast_div, input int slow_div);
    return (fast_div >= 2) && (slow_div >= fast_div) && ((slow_div % fast_div) == 0);
  endfunction

endpackage

// File: rtl/clock_div.sv
// Free-running modulo-DIV counter producing a one-cycle clock enable on its last count.
// The enable is decoded from the registered count, so it never glitches within a period.
module clock_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_en
);

  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("clock_div: DIV must be at least 2");
    end
  endgenerate

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  // Next count wraps to zero after the last count.
  always_comb begin
    cnt_next = cnt + W'(1);
    if (cnt == LAST) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + W'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign clk_en = (cnt == LAST);

endmodule

// File: rtl/nes_clock_gen.sv
// NES master-clock timing generator: PPU/CPU/APU enables, cycle counters, CPU parity
// and the CPU-core enable that is held off while OAM-DMA suspends the CPU.
module nes_clock_gen
  import nes_timing_pkg::*;
#(
  parameter int PPU_DIV = MASTER_PER_PPU,
  parameter int CPU_DIV = MASTER_PER_CPU,
  parameter int APU_DIV = MASTER_PER_APU,
  parameter int CNT_W   = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cpu_sus,
  output logic             ppu_clk_en,
  output logic             cpu_clk_en,
  output logic             apu_clk_en,
  output logic             core_clk_en,
  output logic [CNT_W-1:0] ppu_cycle,
  output logic [CNT_W-1:0] cpu_cycle,
  output logic             cpu_cyc_par
);

  generate
    if (PPU_DIV < 2) begin : g_bad_ppu
      $error("nes_clock_gen: PPU_DIV must be at least 2");
    end
    if (!div_compatible(PPU_DIV, CPU_DIV)) begin : g_bad_cpu
      $error("nes_clock_gen: CPU_DIV must be a multiple of PPU_DIV");
    end
    if (!div_compatible(CPU_DIV, APU_DIV)) begin : g_bad_apu
      $error("nes_clock_gen: APU_DIV must be a multiple of CPU_DIV");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("nes_clock_gen: CNT_W must be at least 1");
    end
  endgenerate

  // All three dividers share one reset, which keeps their pulses phase-aligned.
  clock_div #(.DIV(PPU_DIV)) u_ppu_div (
    .clk    (clock),
    .rst_n  (reset_n),
    .clk_en (ppu_clk_en)
  );

  clock_div #(.DIV(CPU_DIV)) u_cpu_div (
    .clk    (clock),
    .rst_n  (reset_n),
    .clk_en (cpu_clk_en)
  );

  clock_div #(.DIV(APU_DIV)) u_apu_div (
    .clk    (clock),
    .rst_n  (reset_n),
    .clk_en (apu_clk_en)
  );

  logic [CNT_W-1:0] ppu_cycle_next;
  logic [CNT_W-1:0] cpu_cycle_next;

  // Counters advance on the edge that closes their enable period; wrap is natural.
  always_comb begin
    ppu_cycle_next = ppu_cycle;
    cpu_cycle_next = cpu_cycle;
    if (ppu_clk_en) begin
      ppu_cycle_next = ppu_cycle + CNT_W'(1);
    end else begin
      ppu_cycle_next = ppu_cycle;
    end
    if (cpu_clk_en) begin
      cpu_cycle_next = cpu_cycle + CNT_W'(1);
    end else begin
      cpu_cycle_next = cpu_cycle;
    end
  end

  // Cycle counter registers; the CPU count keeps running during DMA suspension.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ppu_cycle <= '0;
      cpu_cycle <= '0;
    end else begin
      ppu_cycle <= ppu_cycle_next;
      cpu_cycle <= cpu_cycle_next;
    end
  end

  assign core_clk_en = cpu_clk_en & ~cpu_sus;
  assign cpu_cyc_par = cpu_cycle[0];

endmodule

// File: tb/tb_nes_clock_gen.sv
// Randomized self-checking bench for nes_clock_gen against an edge-count arithmetic model.
module tb_nes_clock_gen;

  localparam int PD = 4;
  localparam int CD = 12;
  localparam int AD = 24;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_sus = 1'b0;

  logic        ppu_clk_en, cpu_clk_en, apu_clk_en, core_clk_en, cpu_cyc_par;
  logic [63:0] ppu_cycle, cpu_cycle;
  logic        w_ppu_clk_en, w_cpu_clk_en, w_apu_clk_en, w_core_clk_en, w_cpu_cyc_par;
  logic [3:0]  w_ppu_cycle, w_cpu_cycle;

  nes_clock_gen dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_sus     (cpu_sus),
    .ppu_clk_en  (ppu_clk_en),
    .cpu_clk_en  (cpu_clk_en),
    .apu_clk_en  (apu_clk_en),
    .core_clk_en (core_clk_en),
    .ppu_cycle   (ppu_cycle),
    .cpu_cycle   (cpu_cycle),
    .cpu_cyc_par (cpu_cyc_par)
  );

  nes_clock_gen #(.CNT_W(4)) dut_w (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_sus     (cpu_sus),
    .ppu_clk_en  (w_ppu_clk_en),
    .cpu_clk_en  (w_cpu_clk_en),
    .apu_clk_en  (w_apu_clk_en),
    .core_clk_en (w_core_clk_en),
    .ppu_cycle   (w_ppu_cycle),
    .cpu_cycle   (w_cpu_cycle),
    .cpu_cyc_par (w_cpu_cyc_par)
  );

  always #5 clock = ~clock;

  // Model state: number of rising edges since the last reset release.
  int k;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  int n_pass  = 0;
  int n_total = 0;
  int apu_pulses = 0;
  int apu_base;
  logic prev_ppu = 1'b0, prev_cpu = 1'b0, prev_apu = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t (k=%0d)", name, act, exp, $time, k);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Every-cycle comparison against the edge-count model, plus alignment invariants.
  always @(negedge clock) begin
    chk("ppu_clk_en", ppu_clk_en, (k % PD) == PD - 1);
    chk("cpu_clk_en", cpu_clk_en, (k % CD) == CD - 1);
    chk("apu_clk_en", apu_clk_en, (k % AD) == AD - 1);
    chk("core_clk_en", core_clk_en, ((k % CD) == CD - 1) && !cpu_sus);
    chk("ppu_cycle", ppu_cycle, 64'(k / PD));
    chk("cpu_cycle", cpu_cycle, 64'(k / CD));
    chk("cpu_cyc_par", cpu_cyc_par, (k / CD) % 2);
    chk("w_cpu_clk_en", w_cpu_clk_en, (k % CD) == CD - 1);
    chk("w_apu_clk_en", w_apu_clk_en, (k % AD) == AD - 1);
    chk("w_ppu_clk_en", w_ppu_clk_en, (k % PD) == PD - 1);
    chk("w_core_clk_en", w_core_clk_en, ((k % CD) == CD - 1) && !cpu_sus);
    chk("w_ppu_cycle", w_ppu_cycle, (k / PD) % 16);
    chk("w_cpu_cycle", w_cpu_cycle, (k / CD) % 16);
    chk("w_cpu_cyc_par", w_cpu_cyc_par, (k / CD) % 2);
    if (cpu_clk_en) chk("cpu_on_ppu", ppu_clk_en, 1);
    if (apu_clk_en) chk("apu_on_cpu", cpu_clk_en, 1);
    chk("ppu_single", ppu_clk_en & prev_ppu, 0);
    chk("cpu_single", cpu_clk_en & prev_cpu, 0);
    chk("apu_single", apu_clk_en & prev_apu, 0);
    prev_ppu <= ppu_clk_en;
    prev_cpu <= cpu_clk_en;
    prev_apu <= apu_clk_en;
    if (apu_clk_en) apu_pulses <= apu_pulses + 1;
  end

  initial begin
    repeat (3) @(posedge clock);
    #2;
    chk("rst_ppu_cycle", ppu_cycle, 0);
    chk("rst_cpu_cycle", cpu_cycle, 0);
    chk("rst_ppu_en", ppu_clk_en, 0);
    chk("rst_cpu_en", cpu_clk_en, 0);
    chk("rst_apu_en", apu_clk_en, 0);
    chk("rst_par", cpu_cyc_par, 0);

    reset_n  = 1'b1;
    apu_base = apu_pulses;
    for (int e = 1; e <= 260; e++) begin
      tick();
      if (e == 12) chk("par_e12", cpu_cyc_par, 1);
      if (e == 24) chk("par_e24", cpu_cyc_par, 0);
      if (e == 36) chk("par_e36", cpu_cyc_par, 1);
      if (e == 23 || e == 35 || e == 47) begin
        chk("sus_cpu_pulse", cpu_clk_en, 1);
        chk("sus_core_gated", core_clk_en, 0);
      end
      if (e == 48) chk("sus_cpu_cycle_4", cpu_cycle, 4);
      if (e == 59) chk("core_resumes", core_clk_en, 1);
      if (e == 120) begin
        chk("run120_ppu", ppu_cycle, 30);
        chk("run120_cpu", cpu_cycle, 10);
        chk("run120_apu", apu_pulses - apu_base, 5);
        chk("run120_par", cpu_cyc_par, 0);
      end
      if (e == 180) chk("wrap_pre", w_cpu_cycle, 15);
      if (e == 192) chk("wrap_zero", w_cpu_cycle, 0);
      if (e >= 19 && e <= 49) cpu_sus = 1'b1;
      else if (e >= 60)       cpu_sus = 1'($urandom_range(1, 0));
      else                    cpu_sus = 1'b0;
    end

    cpu_sus = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 53; e++) begin
      tick();
      cpu_sus = 1'($urandom_range(1, 0));
    end
    chk("pre_reset_cpu", cpu_cycle, 4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_ppu_cycle", ppu_cycle, 0);
    chk("async_cpu_cycle", cpu_cycle, 0);
    chk("async_par", cpu_cyc_par, 0);
    chk("async_cpu_en", cpu_clk_en, 0);
    chk("async_core_en", core_clk_en, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e <= 11) chk("first_cpu_pulse", cpu_clk_en, e == 11);
      cpu_sus = 1'($urandom_range(1, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
